alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Issuing end of the ALU interface: accepts instruction words on a valid/ready stream and buffers them in a small FIFO.
- Drives the combinational ALU's op_code/operands/carry_in from an internal accumulator and carry flag.
- Captures the ALU result and carry-out back into those registers and returns each result on a valid/ready output stream.
- Sits between the instruction source (bench or upstream control) and the ALU instance at the datapath top level.

Parameters:
- DATA_WIDTH, 8, width of the accumulator, operand and result.
- OPCODE_WIDTH, 3, opcode width; must match the ALU.
- FIFO_DEPTH, 4, number of instruction FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  FIFO can accept.
- in_opcode  in  OPCODE_WIDTH  opcode (share_pkg encoding).
- in_operand  in  DATA_WIDTH  second operand (ALU i_2).
- in_use_carry  in  1  1: alu_cin = carry flag; 0: alu_cin = 0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  DATA_WIDTH  accumulator after the instruction.
- out_carry  out  1  carry flag after the instruction.
- alu_op  out  OPCODE_WIDTH  to ALU op_code.
- alu_a  out  DATA_WIDTH  to ALU i_1 (accumulator).
- alu_b  out  DATA_WIDTH  to ALU i_2 (latched operand).
- alu_cin  out  1  to ALU carry_in.
- alu_result  in  DATA_WIDTH  from ALU o_main.
- alu_cout  in  1  from ALU carry_out.
- busy  out  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset, while rst is high:
  - FIFO is emptied; read and write pointers plus count are set to 0.
  - acc = 0, carry = 0, instruction register = {LOAD_OP, 0, 0}, state = IDLE.
  - out_valid = 0, in_ready = 0, busy = 0.
  - Reset mid-operation discards the in-flight instruction and all queued instructions; no result is emitted.
- Input side:
  - in_ready = !rst && (count < FIFO_DEPTH).
  - A push occurs on an edge where in_valid && in_ready.
  - in_ready does not look ahead for a same-cycle pop: a full FIFO rejects even while popping.
- FIFO behaviour:
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, RESPOND.
  - IDLE: if the FIFO is non-empty, pop its head into the instruction register and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): the ALU settles combinationally. At the edge, acc <= alu_result and carry <= alu_cout, then go to RESPOND.
  - RESPOND: out_valid = 1.
    - On out_ready with FIFO non-empty: pop the next instruction and go to ISSUE (back-to-back).
    - On out_ready with FIFO empty: go to IDLE.
    - Without out_ready: hold; out_result and out_carry stay stable.
- ALU drive:
  - alu_op, alu_b and the use_carry select come from the instruction register; alu_a = acc.
  - alu_cin = use_carry ? carry : 0.
  - All are driven continuously but sampled only in ISSUE.
- Result/carry semantics are passed through from the ALU, unchanged:
  - ADD updates carry with the true carry-out.
  - SUBTRACT computes a - b + cin.
  - AND/OR/XOR/NOT force carry to 0.
  - LOAD_OP and any unlisted opcode load the operand and pass cin through to carry.
  - All results are truncated to DATA_WIDTH.
- Outputs: out_result = acc and out_carry = carry, as registered values.
- Latency: accept in cycle T (edge E0), pop at E1, ISSUE during T+2, out_valid first high in T+3.
- Throughput: one result per 2 cycles with out_ready held high.

Decomposition:
- share_pkg holds:
  - opcode enum: ADD=0, SUBTRACT=1, AND_OP=2, OR_OP=3, XOR_OP=4, NOT_OP=5, LOAD_OP=6.
  - seq_state_t enum {IDLE, ISSUE, RESPOND}.
  - packed instr_t struct {opcode, operand, use_carry}.
- One sub-module, sync_fifo, parameterised by width and depth. It stores instr_t and provides push/pop/full/empty/count.
- The ALU is instantiated beside the sequencer at the top level, not inside it.

Test Plan:
- rst for 2 cycles, then LOAD_OP 0x5A with use_carry=0 -> out_valid in T+3, out_result=0x5A, out_carry=0; in_ready=0 during reset and 1 after.
- LOAD 0xF0; ADD 0x20 (uc=0) -> 0x10, carry=1; ADD 0x01 (uc=1) -> 0x12, carry=0.
- acc=0x10 with carry=1; SUBTRACT 0x03 (uc=1) -> 0x0E, carry=0; a further SUBTRACT 0x03 (uc=0) -> 0x0B.
- LOAD 0xA5; NOT_OP -> 0x5A; XOR 0xFF -> 0xA5, with carry=0 each time.
- Backpressure:
  - Setup: out_ready=0, then push 6 instructions.
  - Required: in_ready drops after the 5th accept (1 in the instruction register + 4 queued) and out_result stays stable.
  - Then raise out_ready: all 6 results arrive in order, spaced 2 cycles apart.
- Reset mid-operation:
  - Setup: pulse rst during ISSUE with 2 instructions queued.
  - Required: the next cycle shows out_valid=0, acc=0, busy=0, and no stale results afterwards.

Source files
------------

// File: rtl/share_pkg.sv
// Shared types for the ALU interface: opcode encoding, sequencer states and
// the packed instruction word that travels through the instruction FIFO.
package share_pkg;

  localparam int SHARE_DATA_W   = 8;
  localparam int SHARE_OPCODE_W = 3;

  typedef enum logic [SHARE_OPCODE_W-1:0] {
    ADD      = 3'd0,
    SUBTRACT = 3'd1,
    AND_OP   = 3'd2,
    OR_OP    = 3'd3,
    XOR_OP   = 3'd4,
    NOT_OP   = 3'd5,
    LOAD_OP  = 3'd6
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } seq_state_t;

  typedef struct packed {
    opcode_t                 opcode;
    logic [SHARE_DATA_W-1:0] operand;
    logic                    use_carry;
  } instr_t;

  localparam int     INSTR_W     = $bits(instr_t);
  localparam instr_t INSTR_RESET = '{opcode: LOAD_OP, operand: '0, use_carry: 1'b0};

  // Packs raw stream fields into an instruction word; unlisted opcode values
  // are carried through unchanged and the ALU treats them like LOAD_OP.
  function automatic instr_t make_instr(input logic [SHARE_OPCODE_W-1:0] opcode,
                                        input logic [SHARE_DATA_W-1:0]   operand,
                                        input logic                      use_carry);
    instr_t i;
    i.opcode    = opcode_t'(opcode);
    i.operand   = operand;
    i.use_carry = use_carry;
    return i;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy update; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issuing end of the ALU interface. Instructions are queued in a FIFO, issued
// one at a time to the external combinational ALU with the accumulator as the
// first operand, and each result is returned on the output stream.
//
// Handshakes: both streams use strict valid/ready. A transfer happens on a
// rising edge where valid and ready are both high; valid, once raised, holds
// its payload stable until that transfer and never depends on ready.
module alu_sequencer
  import share_pkg::*;
#(
  parameter int DATA_WIDTH   = SHARE_DATA_W,
  parameter int OPCODE_WIDTH = SHARE_OPCODE_W,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPCODE_WIDTH-1:0] in_opcode,
  input  logic [DATA_WIDTH-1:0]   in_operand,
  input  logic                    in_use_carry,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_result,
  output logic                    out_carry,
  output logic [OPCODE_WIDTH-1:0] alu_op,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic                    alu_cin,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_cout,
  output logic                    busy
);

  seq_state_t                  state;
  instr_t                      ir;
  logic [DATA_WIDTH-1:0]       acc;
  logic                        carry;

  instr_t                      fifo_wdata;
  logic [INSTR_W-1:0]          fifo_rdata;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // A full FIFO rejects even when a pop happens in the same cycle.
  assign in_ready   = !rst && !fifo_full;
  assign fifo_push  = in_valid && in_ready;
  assign fifo_wdata = make_instr(in_opcode, in_operand, in_use_carry);

  // The next instruction leaves the FIFO exactly when the FSM loads it into ir.
  assign fifo_pop = !rst && !fifo_empty &&
                    ((state == IDLE) || ((state == RESPOND) && out_ready));

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ALU inputs are driven continuously; only the ISSUE cycle result is captured.
  assign alu_op  = ir.opcode;
  assign alu_a   = acc;
  assign alu_b   = ir.operand;
  assign alu_cin = ir.use_carry & carry;

  assign out_result = acc;
  assign out_carry  = carry;
  assign busy       = !rst && ((state != IDLE) || (fifo_count != '0));

  // Sequencer FSM: fetch from FIFO, issue for one cycle, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ir        <= INSTR_RESET;
      acc       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            ir    <= instr_t'(fifo_rdata);
            state <= ISSUE;
          end
        end
        ISSUE: begin
          acc       <= alu_result;
          carry     <= alu_cout;
          out_valid <= 1'b1;
          state     <= RESPOND;
        end
        RESPOND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!fifo_empty) begin
              ir    <= instr_t'(fifo_rdata);
              state <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU beside it.
module tb_alu_sequencer;
  import share_pkg::*;

  localparam int DW = 8;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_opcode;
  logic [DW-1:0] in_operand;
  logic          in_use_carry;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          out_carry;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic          alu_cin;
  logic [DW-1:0] alu_result;
  logic          alu_cout;
  logic          busy;

  int            test_cnt = 0;
  int            fail_cnt = 0;
  int            cyc = 0;
  int            last_hs = 0;
  bit            have_last = 1'b0;
  bit            spacing_on = 1'b0;
  logic [DW:0]   exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_operand   (in_operand),
    .in_use_carry (in_use_carry),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_cin      (alu_cin),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .busy         (busy)
  );

  // Behavioural combinational ALU.
  logic [DW:0] alu_sum;
  always_comb begin
    alu_sum    = '0;
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_op)
      3'd0: begin
        alu_sum    = {1'b0, alu_a} + {1'b0, alu_b} + {{DW{1'b0}}, alu_cin};
        alu_result = alu_sum[DW-1:0];
        alu_cout   = alu_sum[DW];
      end
      3'd1: begin
        alu_sum    = {1'b0, alu_a} - {1'b0, alu_b} + {{DW{1'b0}}, alu_cin};
        alu_result = alu_sum[DW-1:0];
        alu_cout   = alu_sum[DW];
      end
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      3'd5:    alu_result = ~alu_a;
      default: begin
        alu_result = alu_b;
        alu_cout   = alu_cin;
      end
    endcase
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every accepted result is compared in order against exp_q.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 32'(out_valid), 32'd0);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        check("result", 32'({out_carry, out_result}), 32'(e));
        if (spacing_on && have_last) check("spacing", 32'(cyc - last_hs), 32'd2);
        last_hs   = cyc;
        have_last = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input opcode_t op, input logic [DW-1:0] opd, input logic uc,
                      input logic [DW-1:0] er, input logic ec, input bit keep);
    bit ok;
    ok           = 1'b0;
    in_valid     = 1'b1;
    in_opcode    = op;
    in_operand   = opd;
    in_use_carry = uc;
    if (keep) exp_q.push_back({ec, er});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check("push_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_opcode    = '0;
    in_operand   = '0;
    in_use_carry = 1'b0;
    out_ready    = 1'b1;

    // Reset held for two edges.
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acc", 32'({out_carry, out_result}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // First transaction latency: out_valid first high in T+3.
    push(LOAD_OP, 8'h5A, 1'b0, 8'h5A, 1'b0, 1'b1);
    @(negedge clk); check("lat_t1", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_t2", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_t3", 32'(out_valid), 32'd1);
    check("lat_result", 32'({out_carry, out_result}), 32'h05A);
    wait_drain();

    // ADD carry-out and carry-in.
    push(LOAD_OP, 8'hF0, 1'b0, 8'hF0, 1'b0, 1'b1);
    push(ADD,     8'h20, 1'b0, 8'h10, 1'b1, 1'b1);
    push(ADD,     8'h01, 1'b1, 8'h12, 1'b0, 1'b1);
    wait_drain();

    // SUBTRACT with and without carry-in.
    push(LOAD_OP,  8'hF0, 1'b0, 8'hF0, 1'b0, 1'b1);
    push(ADD,      8'h20, 1'b0, 8'h10, 1'b1, 1'b1);
    push(SUBTRACT, 8'h03, 1'b1, 8'h0E, 1'b0, 1'b1);
    push(SUBTRACT, 8'h03, 1'b0, 8'h0B, 1'b0, 1'b1);
    wait_drain();

    // Logic ops clear carry.
    push(LOAD_OP, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b1);
    push(NOT_OP,  8'h00, 1'b0, 8'h5A, 1'b0, 1'b1);
    push(XOR_OP,  8'hFF, 1'b0, 8'hA5, 1'b0, 1'b1);
    wait_drain();

    // Backpressure: 1 held in ir + 4 queued, 6th must wait.
    out_ready = 1'b0;
    push(LOAD_OP, 8'h11, 1'b0, 8'h11, 1'b0, 1'b1);
    push(ADD,     8'h22, 1'b0, 8'h33, 1'b0, 1'b1);
    push(OR_OP,   8'h40, 1'b0, 8'h73, 1'b0, 1'b1);
    push(AND_OP,  8'h0F, 1'b0, 8'h03, 1'b0, 1'b1);
    @(negedge clk);
    check("bp_ready_before_5th", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    push(XOR_OP,  8'h05, 1'b0, 8'h06, 1'b0, 1'b1);
    @(negedge clk);
    check("bp_ready_after_5th", 32'(in_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    cycles(3);
    @(negedge clk);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_result", 32'({out_carry, out_result}), 32'h011);
    check("bp_still_full", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    have_last  = 1'b0;
    spacing_on = 1'b1;
    out_ready  = 1'b1;
    push(ADD, 8'hFF, 1'b0, 8'h05, 1'b1, 1'b1);
    wait_drain();
    spacing_on = 1'b0;

    // Reset during ISSUE with two instructions queued.
    out_ready = 1'b0;
    push(LOAD_OP, 8'h33, 1'b0, 8'h33, 1'b0, 1'b1);
    push(ADD,     8'h01, 1'b0, 8'h34, 1'b0, 1'b0);
    push(ADD,     8'h02, 1'b0, 8'h36, 1'b0, 1'b0);
    push(ADD,     8'h03, 1'b0, 8'h39, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("mid_rst_first_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_rst_in_issue", 32'(out_valid), 32'd0);
    check("mid_rst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_acc", 32'({out_carry, out_result}), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    cycles(10);
    @(negedge clk);
    check("mid_rst_quiet_valid", 32'(out_valid), 32'd0);
    check("mid_rst_quiet_busy", 32'(busy), 32'd0);
    check("mid_rst_no_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
